// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 timing defaults, state encoding and ns->cycle conversion
//
// Purpose : common definitions for the WS2812 transmitter and the LED-side decoder.
//           Bit timings are kept in nanoseconds and converted to clock cycles at the
//           reference clock frequency with WS2812_NS2CYC / ns2cyc (rounded to nearest).
// Ports   : none (package).

`ifndef WS2812_NS2CYC
`define WS2812_NS2CYC(ns, mhz) ((((ns) * (mhz)) + 500) / 1000)
`endif

package ws2812_pkg;

   localparam int CLK_MHZ = 100;

   localparam int T0H_NS  = 350;
   localparam int T0L_NS  = 800;
   localparam int T1H_NS  = 700;
   localparam int T1L_NS  = 600;
   localparam int RET_NS  = 50000;

   localparam int PIXEL_W = 24;

   typedef enum logic [1:0] {
      ST_GAP  = 2'd0,
      ST_IDLE = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_t;

   function automatic int ns2cyc(input int ns);
      return `WS2812_NS2CYC(ns, CLK_MHZ);
   endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// rtl/ws2812_phase_timer.sv - loadable down-counter with a terminal-count strobe
//
// Purpose : times one line phase. Load N-1 to get a phase of exactly N cycles; o_done
//           is high in the final cycle of the phase. The counter parks at zero.
// Ports   : i_clk       clock
//           i_rst       synchronous active-high reset, reloads RST_VAL
//           i_load      load i_load_val at the next edge (wins over counting)
//           i_load_val  value to load (phase length minus one)
//           o_done      counter is zero

module ws2812_phase_timer #(
   parameter int           W       = 13,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_done = (cnt_q == '0);

endmodule

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 NRZ serialiser with one-word holding register and latch gap
//
// Purpose : accepts 24-bit pixels over valid/ready and drives them MSB-first as WS2812
//           pulses on o_serial. Each frame ends (i_last, or an underrun) with a low
//           latch gap of RET_CYC cycles. Reset also starts with a full gap.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           i_data, i_last        pixel word and end-of-frame flag
//           i_valid, o_ready      handshake; transfer on i_valid & o_ready at an edge
//           o_serial              registered WS2812 line
//           o_busy                FSM not idle
//           o_underrun            one-cycle pulse: no word ready at a mid-frame boundary
//           o_underrun_cnt        16-bit saturating underrun count
//                                 (only when WS2812_UNDERRUN_CNT_EN is defined)

module ws2812_tx
   import ws2812_pkg::*;
#(
   parameter int T0H_CYC = ns2cyc(T0H_NS),
   parameter int T0L_CYC = ns2cyc(T0L_NS),
   parameter int T1H_CYC = ns2cyc(T1H_NS),
   parameter int T1L_CYC = ns2cyc(T1L_NS),
   parameter int RET_CYC = ns2cyc(RET_NS)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [PIXEL_W-1:0] i_data,
   input  logic               i_last,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_serial,
   output logic               o_busy,
   output logic               o_underrun
`ifdef WS2812_UNDERRUN_CNT_EN
   ,
   output logic [15:0]        o_underrun_cnt
`endif
);

   localparam int CW = $clog2(RET_CYC);
   localparam int BW = $clog2(PIXEL_W);

   localparam logic [CW-1:0] T0H_LD = CW'(T0H_CYC - 1);
   localparam logic [CW-1:0] T0L_LD = CW'(T0L_CYC - 1);
   localparam logic [CW-1:0] T1H_LD = CW'(T1H_CYC - 1);
   localparam logic [CW-1:0] T1L_LD = CW'(T1L_CYC - 1);
   localparam logic [CW-1:0] RET_LD = CW'(RET_CYC - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PIXEL_W - 1);

   state_t               state_q, state_d;
   logic                 serial_q, serial_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 underrun_q, underrun_d;
   logic                 hold_full_q, hold_full_d;
   logic                 hold_last_q, hold_last_d;
   logic [PIXEL_W-1:0]   hold_data_q, hold_data_d;
   logic [PIXEL_W-1:0]   shift_q, shift_d;
   logic                 last_q, last_d;
   logic [BW-1:0]        bitcnt_q, bitcnt_d;

   logic                 take_hold;
   logic                 tmr_load;
   logic [CW-1:0]        tmr_val;
   logic                 tmr_done;

   ws2812_phase_timer #(
      .W       (CW),
      .RST_VAL (RET_LD)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_done     (tmr_done)
   );

   always_comb begin
      state_d     = state_q;
      serial_d    = serial_q;
      underrun_d  = 1'b0;
      hold_full_d = hold_full_q;
      hold_last_d = hold_last_q;
      hold_data_d = hold_data_q;
      shift_d     = shift_q;
      last_d      = last_q;
      bitcnt_d    = bitcnt_q;
      take_hold   = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = RET_LD;

      // ready_q is ~hold_full_q, so a fill never collides with a drain of the same entry
      if (i_valid && ready_q) begin
         hold_full_d = 1'b1;
         hold_data_d = i_data;
         hold_last_d = i_last;
      end

      case (state_q)
         ST_GAP: begin
            serial_d = 1'b0;
            if (tmr_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (hold_full_q) begin
               take_hold = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tmr_done) begin
               state_d  = ST_LOW;
               serial_d = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = shift_q[PIXEL_W-1] ? T1L_LD : T0L_LD;
            end
         end
         ST_LOW: begin
            if (tmr_done) begin
               if (bitcnt_q != '0) begin
                  // next bit's MSB is the one below the current MSB
                  shift_d  = {shift_q[PIXEL_W-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - BW'(1);
                  state_d  = ST_HIGH;
                  serial_d = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = shift_q[PIXEL_W-2] ? T1H_LD : T0H_LD;
               end else if (last_q) begin
                  state_d  = ST_GAP;
                  tmr_load = 1'b1;
                  tmr_val  = RET_LD;
               end else if (hold_full_q) begin
                  take_hold = 1'b1;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = ST_GAP;
                  tmr_load   = 1'b1;
                  tmr_val    = RET_LD;
               end
            end
         end
         default: begin
            state_d = ST_GAP;
         end
      endcase

      // start a new pixel straight from the holding register (from IDLE or a boundary)
      if (take_hold) begin
         shift_d     = hold_data_q;
         last_d      = hold_last_q;
         hold_full_d = 1'b0;
         bitcnt_d    = LAST_BIT;
         state_d     = ST_HIGH;
         serial_d    = 1'b1;
         tmr_load    = 1'b1;
         tmr_val     = hold_data_q[PIXEL_W-1] ? T1H_LD : T0H_LD;
      end

      busy_d  = (state_d != ST_IDLE);
      ready_d = ~hold_full_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_GAP;
         serial_q    <= 1'b0;
         busy_q      <= 1'b1;
         ready_q     <= 1'b1;
         underrun_q  <= 1'b0;
         hold_full_q <= 1'b0;
         hold_last_q <= 1'b0;
         hold_data_q <= '0;
         shift_q     <= '0;
         last_q      <= 1'b0;
         bitcnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         underrun_q  <= underrun_d;
         hold_full_q <= hold_full_d;
         hold_last_q <= hold_last_d;
         hold_data_q <= hold_data_d;
         shift_q     <= shift_d;
         last_q      <= last_d;
         bitcnt_q    <= bitcnt_d;
      end
   end

   assign o_ready    = ready_q;
   assign o_serial   = serial_q;
   assign o_busy     = busy_q;
   assign o_underrun = underrun_q;

`ifdef WS2812_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_q, urun_cnt_d;

   always_comb begin
      urun_cnt_d = urun_cnt_q;
      if (underrun_q && (urun_cnt_q != 16'hFFFF)) begin
         urun_cnt_d = urun_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         urun_cnt_q <= '0;
      end else begin
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign o_underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - self-checking bench for ws2812_tx

`timescale 1ns/1ps

module tb_ws2812_tx;

   localparam int T0H = 35;
   localparam int T0L = 80;
   localparam int T1H = 70;
   localparam int T1L = 60;
   localparam int RET = 5000;
   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] i_data;
   logic        i_last;
   logic        i_valid;
   logic        o_ready;
   logic        o_serial;
   logic        o_busy;
   logic        o_underrun;
`ifdef WS2812_UNDERRUN_CNT_EN
   logic [15:0] o_underrun_cnt;
`endif

   always #5 clk = ~clk;

   ws2812_tx dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_data     (i_data),
      .i_last     (i_last),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_serial   (o_serial),
      .o_busy     (o_busy),
      .o_underrun (o_underrun)
`ifdef WS2812_UNDERRUN_CNT_EN
      ,
      .o_underrun_cnt (o_underrun_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   // line monitor: measured high/low run lengths
   int runs_hi[$];
   int runs_lo[$];
   int hi_len = 0;
   int lo_len = 0;
   int und_cnt = 0;
   int und_lo = 0;
   bit seen_hi = 1'b0;
   int clr_gen = 0;
   int clr_seen = 0;

   // reference model of the expected frame
   int exp_words[$];
   int exp_hi[$];
   int exp_lo[$];
   int exp_tail;
   int dec_words[$];

   always @(negedge clk) begin
      if (clr_gen != clr_seen) begin
         clr_seen = clr_gen;
         runs_hi.delete();
         runs_lo.delete();
         hi_len = 0;
         lo_len = 0;
         und_cnt = 0;
         und_lo = 0;
         seen_hi = 1'b0;
      end
      if (o_serial === 1'b1) begin
         if (seen_hi && lo_len > 0) runs_lo.push_back(lo_len);
         lo_len = 0;
         hi_len++;
         seen_hi = 1'b1;
      end else begin
         if (hi_len > 0) runs_hi.push_back(hi_len);
         hi_len = 0;
         lo_len++;
      end
      if (o_underrun === 1'b1) begin
         und_cnt++;
         und_lo = lo_len;
      end
   end

   // WS2812 bit rules: '1' = T1H high + T1L low, '0' = T0H high + T0L low; frame ends in a gap
   function automatic void build_model();
      int lows[$];
      exp_hi.delete();
      exp_lo.delete();
      foreach (exp_words[w]) begin
         for (int b = 23; b >= 0; b--) begin
            bit one = ((exp_words[w] >> b) & 1) != 0;
            exp_hi.push_back(one ? T1H : T0H);
            lows.push_back(one ? T1L : T0L);
         end
      end
      exp_tail = lows[lows.size()-1] + RET;
      for (int i = 0; i < lows.size() - 1; i++) exp_lo.push_back(lows[i]);
   endfunction

   function automatic int pixel_cycles(input int w);
      int s = 0;
      for (int b = 23; b >= 0; b--) s += (((w >> b) & 1) != 0) ? (T1H + T1L) : (T0H + T0L);
      return s;
   endfunction

   // what a downstream LED stage would latch, one word per 24 pulses
   function automatic void decode_runs();
      int acc = 0;
      dec_words.delete();
      foreach (runs_hi[i]) begin
         acc = (acc << 1) | ((runs_hi[i] > (T0H + T1H) / 2) ? 1 : 0);
         if ((i % 24) == 23) begin
            dec_words.push_back(acc & 32'h00FF_FFFF);
            acc = 0;
         end
      end
   endfunction

   function automatic int first_diff(input int a[$], input int b[$]);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   task automatic clear_monitor();
      clr_gen++;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] d, input bit last, output int waits);
      bit ok = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last;
      waits   = 0;
      while (waits < LIMIT) begin
         if (o_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         waits++;
      end
      i_valid = 1'b0;
      i_data  = 24'($urandom);
      i_last  = 1'($urandom);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_handshake data=%06h got=timeout required=accept", d);
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 1;
      @(posedge clk);
      #1;
      while (o_busy !== 1'b0 && cyc < LIMIT) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (o_busy !== 1'b0) cyc = -1;
   endtask

   task automatic test_reset();
      int cyc = 0;
      bit low_ok = 1'b1;
      bit rdy_ok = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_last  = 1'b0;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_serial !== 1'b0) begin errors++; $display("FAIL rst_serial got=%b required=0", o_serial); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b required=1", o_busy); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b required=1", o_ready); end
      checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b required=0", o_underrun); end
      rst = 1'b0;
      while (o_busy === 1'b1 && cyc < RET + 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (o_serial !== 1'b0) low_ok = 1'b0;
         if (o_ready !== 1'b1) rdy_ok = 1'b0;
      end
      checks++; if (cyc != RET) begin errors++; $display("FAIL rst_gap_len got=%0d required=%0d", cyc, RET); end
      checks++; if (!low_ok) begin errors++; $display("FAIL rst_gap_low got=high required=low"); end
      checks++; if (!rdy_ok) begin errors++; $display("FAIL rst_gap_ready got=0 required=1"); end
   endtask

   task automatic test_single_pixel();
      int w, cyc, d;
      clear_monitor();
      exp_words = '{32'hF0F0FF};
      build_model();
      send(24'hF0F0FF, 1'b1, w);
      checks++; if (o_serial !== 1'b0) begin errors++; $display("FAIL single_latency0 got=%b required=0", o_serial); end
      @(posedge clk);
      #1;
      checks++; if (o_serial !== 1'b1) begin errors++; $display("FAIL single_latency1 got=%b required=1", o_serial); end
      wait_idle(cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL single_idle got=timeout required=idle"); end
      checks++; if (lo_len != exp_tail) begin errors++; $display("FAIL single_tail got=%0d required=%0d", lo_len, exp_tail); end
      d = first_diff(runs_hi, exp_hi);
      checks++; if (d != -1) begin errors++; $display("FAIL single_high idx=%0d got_n=%0d required_n=%0d", d, runs_hi.size(), exp_hi.size()); end
      d = first_diff(runs_lo, exp_lo);
      checks++; if (d != -1) begin errors++; $display("FAIL single_low idx=%0d got_n=%0d required_n=%0d", d, runs_lo.size(), exp_lo.size()); end
   endtask

   task automatic test_chain();
      int w, cyc, d;
      clear_monitor();
      exp_words = '{32'hF0F0FF, 32'h00FF00};
      build_model();
      send(24'hF0F0FF, 1'b0, w);
      send(24'h00FF00, 1'b1, w);
      wait_idle(cyc);
      decode_runs();
      checks++; if (cyc < 0) begin errors++; $display("FAIL chain_idle got=timeout required=idle"); end
      checks++; if (lo_len != exp_tail) begin errors++; $display("FAIL chain_tail got=%0d required=%0d", lo_len, exp_tail); end
      d = first_diff(runs_hi, exp_hi);
      checks++; if (d != -1) begin errors++; $display("FAIL chain_high idx=%0d got_n=%0d required_n=%0d", d, runs_hi.size(), exp_hi.size()); end
      d = first_diff(runs_lo, exp_lo);
      checks++; if (d != -1) begin errors++; $display("FAIL chain_low idx=%0d got_n=%0d required_n=%0d", d, runs_lo.size(), exp_lo.size()); end
      d = first_diff(dec_words, exp_words);
      checks++; if (d != -1) begin errors++; $display("FAIL chain_leds idx=%0d got_n=%0d required_n=%0d", d, dec_words.size(), exp_words.size()); end
   endtask

   task automatic test_underrun();
      int w, cyc, d;
      clear_monitor();
      exp_words = '{32'hAAAAAA};
      build_model();
      send(24'hAAAAAA, 1'b0, w);
      wait_idle(cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL urun_idle got=timeout required=idle"); end
      checks++; if (und_cnt != 1) begin errors++; $display("FAIL urun_pulses got=%0d required=1", und_cnt); end
      checks++; if (und_lo != exp_tail - RET + 1) begin errors++; $display("FAIL urun_when got=%0d required=%0d", und_lo, exp_tail - RET + 1); end
      checks++; if (lo_len != exp_tail) begin errors++; $display("FAIL urun_tail got=%0d required=%0d", lo_len, exp_tail); end
      d = first_diff(runs_hi, exp_hi);
      checks++; if (d != -1) begin errors++; $display("FAIL urun_high idx=%0d got_n=%0d required_n=%0d", d, runs_hi.size(), exp_hi.size()); end
`ifdef WS2812_UNDERRUN_CNT_EN
      checks++; if (o_underrun_cnt !== 16'd1) begin errors++; $display("FAIL urun_cnt got=%0d required=1", o_underrun_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      int w1, w2, w3, wt1, wt2, wt3, cyc, d;
      w1 = int'(24'($urandom));
      w2 = int'(24'($urandom));
      w3 = int'(24'($urandom));
      clear_monitor();
      exp_words = '{w1, w2, w3};
      build_model();
      send(24'(w1), 1'b0, wt1);
      send(24'(w2), 1'b0, wt2);
      send(24'(w3), 1'b1, wt3);
      checks++; if (wt2 != 1) begin errors++; $display("FAIL bp_wait2 got=%0d required=1", wt2); end
      checks++; if (wt3 != pixel_cycles(w1) - 1) begin errors++; $display("FAIL bp_wait3 got=%0d required=%0d", wt3, pixel_cycles(w1) - 1); end
      wait_idle(cyc);
      decode_runs();
      checks++; if (cyc < 0) begin errors++; $display("FAIL bp_idle got=timeout required=idle"); end
      d = first_diff(runs_hi, exp_hi);
      checks++; if (d != -1) begin errors++; $display("FAIL bp_high idx=%0d got_n=%0d required_n=%0d", d, runs_hi.size(), exp_hi.size()); end
      d = first_diff(dec_words, exp_words);
      checks++; if (d != -1) begin errors++; $display("FAIL bp_words idx=%0d got_n=%0d required_n=%0d", d, dec_words.size(), exp_words.size()); end
      checks++; if (lo_len != exp_tail) begin errors++; $display("FAIL bp_tail got=%0d required=%0d", lo_len, exp_tail); end
   endtask

   task automatic test_midbit_reset();
      int w, cyc = 0, d, p1, p2;
      bit low_ok = 1'b1;
      p1 = int'(24'($urandom) | 24'h800000);
      p2 = int'(24'($urandom));
      send(24'(p1), 1'b1, w);
      @(posedge clk);
      #1;
      checks++; if (o_serial !== 1'b1) begin errors++; $display("FAIL mbr_high got=%b required=1", o_serial); end
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (o_serial !== 1'b0) begin errors++; $display("FAIL mbr_cut got=%b required=0", o_serial); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mbr_ready got=%b required=1", o_ready); end
`ifdef WS2812_UNDERRUN_CNT_EN
      checks++; if (o_underrun_cnt !== 16'd0) begin errors++; $display("FAIL mbr_cnt got=%0d required=0", o_underrun_cnt); end
`endif
      while (o_busy === 1'b1 && cyc < RET + 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (o_serial !== 1'b0) low_ok = 1'b0;
      end
      checks++; if (cyc != RET) begin errors++; $display("FAIL mbr_gap_len got=%0d required=%0d", cyc, RET); end
      checks++; if (!low_ok) begin errors++; $display("FAIL mbr_gap_low got=high required=low"); end
      clear_monitor();
      exp_words = '{p2};
      build_model();
      send(24'(p2), 1'b1, w);
      wait_idle(cyc);
      decode_runs();
      checks++; if (cyc < 0) begin errors++; $display("FAIL mbr_idle got=timeout required=idle"); end
      d = first_diff(dec_words, exp_words);
      checks++; if (d != -1) begin errors++; $display("FAIL mbr_word idx=%0d got_n=%0d required_n=%0d", d, dec_words.size(), exp_words.size()); end
      d = first_diff(runs_lo, exp_lo);
      checks++; if (d != -1) begin errors++; $display("FAIL mbr_low idx=%0d got_n=%0d required_n=%0d", d, runs_lo.size(), exp_lo.size()); end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_chain();
      test_underrun();
      test_backpressure();
      test_midbit_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
